// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 constants, FSM state encoding and access-size helper for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_MERGE_WR = 2'd2,
        ST_RESP     = 2'd3
    } lsu_state_e;

    // Illegal encodings report 4; they fault on the funct3 check anyway.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load byte/halfword extraction with extension, and sub-word store merge
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = word[{lane, 3'b000} +: 8];
        half_sel  = word[{lane[1], 4'b0000} +: 16];
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (funct3)
            F3_B:    merged[{lane, 3'b000} +: 8]      = wdata[7:0];
            F3_H:    merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store sequencer with read-modify-write for sub-word stores
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_write,
    output logic            mem_read,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e      state_q, state_d;
    logic            store_q, store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] merged_q, merged_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_fault_q, resp_fault_d;

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged;
    logic [2:0]      req_size;
    logic [XLEN:0]   last_byte;
    logic            funct_bad, misaligned, range_bad, req_fault;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3    (funct3_q),
        .lane      (addr_q[1:0]),
        .word      (mem_rdata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // One extra bit on the end address so a request near 0xFFFFFFFF cannot wrap into range.
    always_comb begin
        req_size   = access_size(req_funct3);
        last_byte  = {1'b0, req_addr} + (XLEN+1)'(req_size) - (XLEN+1)'(1);
        if (req_store) begin
            funct_bad = !(req_funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            funct_bad = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        misaligned = ((req_size == 3'd2) && req_addr[0]) ||
                     ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
        range_bad  = last_byte >= (XLEN+1)'(MEM_BYTES);
        req_fault  = funct_bad || misaligned || range_bad;
    end

    assign mem_addr   = {addr_q[XLEN-1:2], 2'b00};
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;

    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        merged_d     = merged_q;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_wdata    = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_fault) begin
                        resp_rdata_d = '0;
                        resp_fault_d = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (!store_q) begin
                    mem_read     = 1'b1;
                    resp_rdata_d = load_data;
                    resp_fault_d = 1'b0;
                    state_d      = ST_RESP;
                end else if (funct3_q == F3_W) begin
                    mem_write    = 1'b1;
                    mem_wdata    = wdata_q;
                    resp_rdata_d = '0;
                    resp_fault_d = 1'b0;
                    state_d      = ST_RESP;
                end else begin
                    mem_read = 1'b1;
                    merged_d = merged;
                    state_d  = ST_MERGE_WR;
                end
            end
            ST_MERGE_WR: begin
                mem_write    = 1'b1;
                mem_wdata    = merged_q;
                resp_rdata_d = '0;
                resp_fault_d = 1'b0;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            store_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            merged_q     <= '0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            merged_q     <= merged_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - vector table, reset corner sequences and randomized model check of load_store_unit
module tb_load_store_unit;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEM_BYTES), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata)
    );

    // Word-wide data memory the unit talks to; preloaded through its own port during reset.
    logic [31:0] tb_mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) tb_mem[pl_idx] <= pl_data;
        else if (mem_write) tb_mem[mem_addr[9:2]] <= mem_wdata;
    end
    assign mem_rdata = tb_mem[mem_addr[9:2]];

    // Reference model state: plain byte array.
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          nwr;
        int          nrd;
        logic [31:0] wword;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input logic flt,
                                input int lat, input int nwr, input int nrd, input logic [31:0] ww);
        vec_t v;
        v.store = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.fault = flt;
        v.lat = lat; v.nwr = nwr; v.nrd = nrd; v.wword = ww;
        return v;
    endfunction

    // Expected outcome straight from the RV32I access rules; applies stores to ref_mem.
    task automatic model_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output vec_t v);
        int          size;
        logic        legal;
        longint      la;
        logic [31:0] val;
        logic [31:0] wa;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        la = longint'({32'd0, a});
        v.store = st; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.fault = !legal || ((la % size) != 0) || (la + size > MEM_BYTES);
        v.rdata = 32'd0; v.nwr = 0; v.nrd = 0; v.wword = 32'd0; v.lat = 1;
        if (!v.fault) begin
            if (st) begin
                for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
                wa = a & ~32'd3;
                v.wword = {ref_mem[wa+3], ref_mem[wa+2], ref_mem[wa+1], ref_mem[wa]};
                v.nwr = 1;
                v.nrd = (size < 4) ? 1 : 0;
                v.lat = (size < 4) ? 3 : 2;
            end else begin
                val = 32'd0;
                for (int i = 0; i < size; i++) val = val | (32'(ref_mem[a + i]) << (8*i));
                if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 32'd1);
                v.rdata = val;
                v.nrd = 1;
                v.lat = 2;
            end
        end
    endtask

    // Issue one request and compare everything observable against exp.
    task automatic run_req(input string tag, input vec_t exp);
        int          guard, lat, nwr, nrd;
        logic [31:0] wword;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk({tag, " ready_timeout"}, {31'd0, req_ready}, 32'd1);
            return;
        end
        req_valid = 1'b1; req_store = exp.store; req_funct3 = exp.f3;
        req_addr = exp.addr; req_wdata = exp.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1; nwr = 0; nrd = 0; wword = 32'd0;
        @(negedge clk);
        while (!resp_valid && lat < 10) begin
            if (mem_write) begin nwr++; wword = mem_wdata; end
            if (mem_read) nrd++;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, exp.lat);
        chk({tag, " rdata"}, resp_rdata, exp.rdata);
        chk({tag, " fault"}, {31'd0, resp_fault}, {31'd0, exp.fault});
        chk({tag, " write_count"}, nwr, exp.nwr);
        chk({tag, " read_count"}, nrd, exp.nrd);
        if (exp.nwr != 0) chk({tag, " write_word"}, wword, exp.wword);
        @(negedge clk);
        chk({tag, " valid_pulse"}, {31'd0, resp_valid}, 32'd0);
    endtask

    vec_t tbl [$];
    vec_t m;
    int   nwr_rst;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; pl_en = 1'b1; pl_idx = 8'd0; pl_data = 32'd0;

        for (int i = 0; i < 256; i++) begin
            pl_idx  = 8'(i);
            pl_data = (i == 4) ? 32'h8899AABB : (i == 255) ? 32'h12345678 : $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = pl_data[8*b +: 8];
            @(posedge clk);
            #1;
        end
        pl_en = 1'b0;

        @(negedge clk);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_fault", {31'd0, resp_fault}, 32'd0);
        chk("reset mem_write", {31'd0, mem_write}, 32'd0);
        chk("reset mem_read", {31'd0, mem_read}, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        //            st    f3     addr            wdata           rdata           flt  lat wr rd wword
        tbl.push_back(mk(1'b0, 3'd0, 32'h0000_0013, 32'h0,         32'hFFFF_FF88, 1'b0, 2, 0, 1, 32'h0));
        tbl.push_back(mk(1'b0, 3'd4, 32'h0000_0013, 32'h0,         32'h0000_0088, 1'b0, 2, 0, 1, 32'h0));
        tbl.push_back(mk(1'b0, 3'd5, 32'h0000_0012, 32'h0,         32'h0000_8899, 1'b0, 2, 0, 1, 32'h0));
        tbl.push_back(mk(1'b1, 3'd0, 32'h0000_0011, 32'h0000_00CC, 32'h0,         1'b0, 3, 1, 1, 32'h8899_CCBB));
        tbl.push_back(mk(1'b0, 3'd2, 32'h0000_0010, 32'h0,         32'h8899_CCBB, 1'b0, 2, 0, 1, 32'h0));
        tbl.push_back(mk(1'b0, 3'd1, 32'h0000_0012, 32'h0,         32'hFFFF_8899, 1'b0, 2, 0, 1, 32'h0));
        tbl.push_back(mk(1'b1, 3'd2, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1, 0, 32'hDEAD_BEEF));
        tbl.push_back(mk(1'b0, 3'd2, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0, 1, 32'h0));
        tbl.push_back(mk(1'b1, 3'd1, 32'h0000_0022, 32'h1234_5678, 32'h0,         1'b0, 3, 1, 1, 32'h5678_BEEF));
        tbl.push_back(mk(1'b0, 3'd5, 32'h0000_0022, 32'h0,         32'h0000_5678, 1'b0, 2, 0, 1, 32'h0));
        tbl.push_back(mk(1'b0, 3'd2, 32'h0000_0022, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1'b1, 3'd1, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0,         1'b1, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1'b0, 3'd2, 32'h0000_03FC, 32'h0,         32'h1234_5678, 1'b0, 2, 0, 1, 32'h0));
        tbl.push_back(mk(1'b0, 3'd2, 32'h0000_0400, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1'b0, 3'd1, 32'h0000_03FE, 32'h0,         32'h0000_1234, 1'b0, 2, 0, 1, 32'h0));
        tbl.push_back(mk(1'b0, 3'd0, 32'h0000_03FF, 32'h0,         32'h0000_0012, 1'b0, 2, 0, 1, 32'h0));
        tbl.push_back(mk(1'b0, 3'd1, 32'h0000_03FF, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1'b0, 3'd3, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1'b1, 3'd4, 32'h0000_0010, 32'h0000_0055, 32'h0,         1'b1, 1, 0, 0, 32'h0));

        foreach (tbl[i]) begin
            model_req(tbl[i].store, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m);
            run_req($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset during the read half of an SB: memory must stay untouched.
        nwr_rst = 0;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        if (mem_write) nwr_rst++;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        if (mem_write) nwr_rst++;
        chk("rst_access req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_access resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_access writes", nwr_rst, 0);
        chk("rst_access word", tb_mem[4], 32'h8899_CCBB);

        // Reset during MERGE_WR: the already-decoded write still lands.
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h10; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_merge strobe", {31'd0, mem_write}, 32'd1);
        chk("rst_merge wdata", mem_wdata, 32'h8899_CC77);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_merge word", tb_mem[4], 32'h8899_CC77);
        chk("rst_merge req_ready", {31'd0, req_ready}, 32'd1);
        ref_mem[32'h10] = 8'h77;
        model_req(1'b0, 3'd2, 32'h10, 32'h0, m);
        run_req("post_rst_lw", m);

        for (int k = 0; k < 300; k++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       a = $urandom;
                1:       a = 32'h3F8 + 32'($urandom_range(0, 15));
                default: a = 32'($urandom_range(0, MEM_BYTES - 1));
            endcase
            model_req(st, f3, a, $urandom, m);
            run_req($sformatf("rnd%0d", k), m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the byte-addressed, word-wide data memory.
- Turns RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned memory accesses.
- Loads: extracts and sign- or zero-extends the addressed bytes.
- Sub-word stores: read-modify-write, because the memory always writes a full 4-byte word.
- Misaligned, illegal and out-of-range accesses are flagged; they never reach memory.

Parameters:
- MEM_BYTES, 1024: data memory size in bytes; an access is in range iff addr+size-1 < MEM_BYTES.
- XLEN, 32: data and address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the access.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data (low bytes used for SB/SH).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load result; 0 for stores and faults.
- resp_fault  out  1  valid with resp_valid: misaligned, illegal funct3 or out of range.
- mem_addr  out  XLEN  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  XLEN  full word to write.
- mem_write  out  1  write strobe; memory commits at the next clk edge.
- mem_read  out  1  read qualifier.
- mem_rdata  in  XLEN  combinational read data for mem_addr.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - Reset sets state=IDLE, resp_valid=0, resp_rdata=0, resp_fault=0.
  - mem_write, mem_read and mem_wdata are decoded from state, so they read 0 after the reset edge.
- States: IDLE, ACCESS, MERGE_WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch store, funct3, addr and wdata.
  - Faulting request -> RESP with fault=1, no memory strobe.
  - Otherwise -> ACCESS.
- ACCESS (mem_addr = latched aligned address):
  - Load: mem_read=1; capture extracted mem_rdata into resp_rdata -> RESP.
  - SW: mem_write=1, mem_wdata=wdata -> RESP.
  - SB/SH: mem_read=1; register mem_rdata with the target byte/halfword replaced by wdata[7:0]/[15:0] at lane addr[1:0] -> MERGE_WR.
- MERGE_WR: mem_write=1, mem_wdata=merged word -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. resp_rdata/resp_fault hold until the next RESP.
- Latency (accept edge to resp_valid): load and SW 2 cycles; SB/SH 3 cycles; fault 1 cycle. Next request can be accepted the cycle after RESP.
- Fault rules:
  - LH/LHU/SH with addr[0]=1 -> fault.
  - LW/SW with addr[1:0]!=0 -> fault.
  - Loads with funct3 011/110/111 -> fault.
  - Stores with funct3 other than 000/001/010 -> fault.
  - addr+size-1 >= MEM_BYTES (compute in XLEN+1 bits so wrap at 0xFFFFFFFF faults) -> fault.
- Extraction: byte lane addr[1:0], halfword lane addr[1]. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- req_valid outside IDLE is ignored; the requester holds it until it sees req_ready.
- Reset mid-operation: RMW aborted in ACCESS leaves memory unchanged. Reset asserted during MERGE_WR does not block that cycle's write, since the strobe is already decoded.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encoding.
  - Size-from-funct3 function.
- Sub-module lsu_align (combinational):
  - load extract/extend: funct3, addr[1:0], word -> rdata.
  - store merge: funct3, addr[1:0], old word, wdata -> merged word.
- FSM and registers stay in load_store_unit.

Test Plan:
- Memory word @0x10 = 0x8899AABB.
  - LB addr 0x13 -> resp_rdata 0xFFFFFF88, 2 cycles, fault 0.
  - LBU 0x13 -> 0x00000088.
  - LHU 0x12 -> 0x00008899.
- SB addr 0x11, wdata 0x000000CC onto 0x8899AABB:
  - exactly one mem_write pulse in MERGE_WR with mem_wdata 0x8899CCBB;
  - resp_valid 3 cycles after accept;
  - a following LW 0x10 returns 0x8899CCBB.
- SW 0x20, wdata 0xDEADBEEF -> single mem_write in ACCESS, no mem_read; LW 0x20 -> 0xDEADBEEF.
- LW 0x22, then SH 0x13 -> each resp_fault=1 after 1 cycle, mem_write never asserted, resp_rdata 0.
- Out of range (MEM_BYTES=1024):
  - LW 0x3FC -> ok; LW 0x400 -> fault.
  - LB 0xFFFFFFFF -> fault, no wrap.
- Reset asserted in ACCESS of an SB:
  - next cycle state IDLE, req_ready=1, no mem_write seen;
  - target word unchanged.
